// File: rtl/mips_pkg.sv
// Shared definitions for the multiply sequencer.
//   mult_state_t : sequencer state (IDLE, RUN, FIN), 2-bit encoding
//   MULT_WIDTH   : default operand width
//   cnt_width()  : width of the step counter for a given operand width
package mips_pkg;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_FIN  = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH = 32;

    // The counter must hold 0..WIDTH-1 with headroom, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add multiply sequencer owning the HI/LO registers.
// One partial-product step is done per clock. The full product is written to
// hi/lo WIDTH+1 clocks after start is accepted.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   start     : multiply request, sampled only while idle
//   is_signed : 1 = two's-complement multiply, 0 = unsigned; sampled with start
//   a, b      : multiplicand (rs) and multiplier (rt)
//   busy      : high while a multiply is in progress
//   done      : one-cycle pulse when hi/lo hold the new product
//   hi, lo    : upper and lower halves of the last product
module mult_seq_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // Unsigned magnitude of an operand. For signed mode the most negative
    // value maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    mult_state_t        state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mcand;
    // Upper half accumulates partial products; lower half starts as the
    // multiplier and is shifted out one bit per step as product bits shift in.
    logic [2*WIDTH-1:0] acc;
    logic               neg_flag;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MULT_IDLE;
            count    <= '0;
            mcand    <= '0;
            acc      <= '0;
            neg_flag <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MULT_IDLE: begin
                    if (start) begin
                        mcand    <= magnitude(a, is_signed);
                        acc      <= {{WIDTH{1'b0}}, magnitude(b, is_signed)};
                        neg_flag <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= MULT_RUN;
                    end
                end
                MULT_RUN: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= MULT_FIN;
                    end
                end
                MULT_FIN: begin
                    {hi, lo} <= neg_flag ? negate(acc) : acc;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= MULT_IDLE;
                end
                default: begin
                    state <= MULT_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: the driver pushes the expected product
// and completion cycle for every accepted request; a monitor on the falling
// edge pops and compares on done, and checks busy and hi/lo hold otherwise.
module tb_mult_seq_ctrl;

    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    exp_t           q[$];
    logic [2*W-1:0] last_prod = '0;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic         s);
        longint sx;
        longint sy;
        logic [2*W-1:0] ux;
        logic [2*W-1:0] uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'b0, x};
        uy = {32'b0, y};
        return ux * uy;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on done, busy and hold checks otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && cyc > q[0].due) begin
                chk("missing_done", 64'(cyc), 64'(q[0].due));
                void'(q.pop_front());
            end
            chk("busy", 64'(busy), 64'((q.size() > 0) && (cyc < q[0].due)));
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'(0));
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(q[0].due));
                    chk("product", {hi, lo}, q[0].prod);
                    last_prod = q[0].prod;
                    void'(q.pop_front());
                end
            end else begin
                chk("hold", {hi, lo}, last_prod);
            end
        end
    end

    // Present a request; sync=1 first aligns to a falling edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input bit sync);
        exp_t e;
        if (sync) @(negedge clk);
        start     = 1'b1;
        a         = x;
        b         = y;
        is_signed = s;
        @(posedge clk);
        #1;
        e.prod = ref_mul(x, y, s);
        e.due  = cyc + W + 1;
        q.push_back(e);
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("timeout", 64'(q.size()), 64'(0));
            q.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        issue(x, y, s, 1'b1);
        wait_done();
    endtask

    initial begin
        int d;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        #2 rst = 1'b0;

        // Directed cases
        run(32'd3, 32'd5, 1'b0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(32'hFFFF_FFFE, 32'd3, 1'b1);
        run(32'h8000_0000, 32'h8000_0000, 1'b1);
        run(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        run(32'd0, 32'hFFFF_FFFF, 1'b1);

        // Start while busy is ignored
        issue(32'd11, 32'd13, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd7; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        // Back-to-back: new start presented in the done cycle
        issue(32'd9, 32'hFFFF_FFF0, 1'b1, 1'b1);
        d = q[0].due;
        while (cyc < d) @(negedge clk);
        issue(32'd2, 32'd2, 1'b0, 1'b0);
        wait_done();

        // Randomized operations
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = 32'h8000_0000;
            if (i % 4 == 2) rb = 32'hFFFF_FFFF;
            run(ra, rb, 1'($urandom));
        end

        // Reset in the middle of a run
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        q.delete();
        last_prod = '0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_hi", 64'(hi), 64'(0));
        chk("mid_rst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        run(32'hFFFF_FFF9, 32'd6, 1'b1);
        run(32'd100, 32'd200, 1'b0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
